// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Purpose:
//   Round-robin arbiter for 8 requesters. It grants one requester at a time
//   and presents the grant both as a binary index and as a one-hot vector.
//   A grant is held until the holder strobes done or drops its request.
//   Every grant is followed by a one-cycle RELEASE slot, and then by an IDLE
//   cycle in which the next winner is picked.
//
// Optional feature:
//   DECODER_ARB_TIMEOUT_EN - when defined, a hold counter forces a release
//   after TIMEOUT_CYCLES grant cycles and pulses timeout for that RELEASE
//   cycle. When undefined, there is no counter, timeout is tied low, and a
//   grant is held indefinitely.
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   enable       in   1  arbiter enable; low forces IDLE and drops the grant
//   req          in   8  request lines, bit i = requester i
//   done         in   1  release strobe from the current grant holder
//   grant_idx    out  3  binary index of the granted requester (sticky)
//   grant_valid  out  1  high while a grant is held
//   grant        out  8  one-hot grant, 8'h00 when no grant is held
//   timeout      out  1  one-cycle pulse on a forced (timed-out) release
//
// States:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | no grant; picks a round-robin winner when enabled and req!=0
//   GRANT    | grant held stable; waits for done, request drop or timeout
//   RELEASE  | single dead cycle after a grant, then back to IDLE
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic [7:0] grant,
  output logic       timeout
);

  // The hold counter is 8 bits wide, so the limit must fit in it; a limit
  // below 2 would make every grant a single cycle long.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("decoder_rr_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] winner;

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // First set request after ptr, scanning upward with wrap. Offset 8 wraps
  // back onto ptr itself, so the previous holder wins only when it is the
  // sole requester.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner = rr_pick(req, ptr_q);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
`ifdef DECODER_ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
`endif

    if (!enable) begin
      // Disabling is an abort, not a release: no RELEASE slot and no timeout.
      // ptr is left alone so fairness resumes where it stopped.
      state_d       = ST_IDLE;
      grant_valid_d = 1'b0;
      grant_d       = 8'h00;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_d       = ST_GRANT;
            ptr_d         = winner;
            grant_idx_d   = winner;
            grant_valid_d = 1'b1;
            grant_d       = 8'd1 << winner;
`ifdef DECODER_ARB_TIMEOUT_EN
            hold_cnt_d    = 8'd0;
`endif
          end
        end

        ST_GRANT: begin
          // A normal release is checked first so that it wins over a timeout
          // landing in the same cycle.
          if (done || !req[grant_idx_q]) begin
            state_d       = ST_RELEASE;
            grant_valid_d = 1'b0;
            grant_d       = 8'h00;
          end
`ifdef DECODER_ARB_TIMEOUT_EN
          // This is the last permitted grant cycle once the incremented
          // count reaches the limit, so the grant lasts exactly
          // TIMEOUT_CYCLES cycles.
          else if (hold_cnt_q + 8'd1 == HOLD_LIMIT) begin
            state_d       = ST_RELEASE;
            grant_valid_d = 1'b0;
            grant_d       = 8'h00;
            timeout_d     = 1'b1;
          end else begin
            hold_cnt_d    = hold_cnt_q + 8'd1;
          end
`endif
        end

        ST_RELEASE: begin
          // No arbitration here: a request that arrived alongside the
          // release is picked up in the following IDLE cycle.
          state_d = ST_IDLE;
        end

        default: begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          grant_d       = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 3'd7;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      grant_q       <= 8'h00;
`ifdef DECODER_ARB_TIMEOUT_EN
      hold_cnt_q    <= 8'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
`ifdef DECODER_ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
`ifdef DECODER_ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] grant;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  decoder_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant       (grant),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [7:0] rq;
    logic       dn;
    logic       v;
    logic [2:0] idx;
    logic [7:0] g;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] g, input logic t);
    check({tag, ".valid"},   32'(grant_valid), 32'(v));
    check({tag, ".idx"},     32'(grant_idx),   32'(idx));
    check({tag, ".grant"},   32'(grant),       32'(g));
    check({tag, ".timeout"}, 32'(timeout),     32'(t));
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; req = 8'hFF; done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    int hold;
    logic [2:0] exp_idx;
    logic persist_ok;

    //            en    req    done  valid idx   grant
    vecs[0]  = '{1'b1, 8'h81, 1'b0, 1'b1, 3'd0, 8'h01};  // first search starts at 0
    vecs[1]  = '{1'b1, 8'h81, 1'b1, 1'b0, 3'd0, 8'h00};  // done -> RELEASE
    vecs[2]  = '{1'b1, 8'h81, 1'b1, 1'b0, 3'd0, 8'h00};  // RELEASE -> IDLE, done ignored
    vecs[3]  = '{1'b1, 8'h81, 1'b0, 1'b1, 3'd7, 8'h80};  // ptr=0 -> winner 7
    vecs[4]  = '{1'b1, 8'h81, 1'b0, 1'b1, 3'd7, 8'h80};  // held
    vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd7, 8'h00};  // req[7] dropped -> RELEASE
    vecs[6]  = '{1'b1, 8'h08, 1'b0, 1'b0, 3'd7, 8'h00};  // IDLE, idx sticky
    vecs[7]  = '{1'b1, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08};  // wrap 7 -> 0.. -> 3
    vecs[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00};  // req[3] dropped, no done
    vecs[9]  = '{1'b1, 8'h09, 1'b0, 1'b0, 3'd3, 8'h00};  // IDLE
    vecs[10] = '{1'b1, 8'h09, 1'b1, 1'b1, 3'd0, 8'h01};  // ptr=3 -> 0; done in IDLE ignored
    vecs[11] = '{1'b1, 8'h09, 1'b1, 1'b0, 3'd0, 8'h00};  // done + pending req3: release wins
    vecs[12] = '{1'b1, 8'h09, 1'b0, 1'b0, 3'd0, 8'h00};  // IDLE
    vecs[13] = '{1'b1, 8'h09, 1'b0, 1'b1, 3'd3, 8'h08};  // ptr=0 -> 3
    vecs[14] = '{1'b0, 8'h09, 1'b0, 1'b0, 3'd3, 8'h00};  // enable low mid-grant
    vecs[15] = '{1'b0, 8'h10, 1'b0, 1'b0, 3'd3, 8'h00};  // still disabled, no grant
    vecs[16] = '{1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 8'h10};  // re-enabled -> grant 8'h10
    vecs[17] = '{1'b1, 8'h10, 1'b1, 1'b0, 3'd4, 8'h00};  // done
    vecs[18] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd4, 8'h00};  // IDLE
    vecs[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 3'd4, 8'h00};  // no request, stays idle

    // Reset with enable and requests active: reset must win.
    do_reset();
    check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      enable = vecs[i].en;
      req    = vecs[i].rq;
      done   = vecs[i].dn;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].g, 1'b0);
    end

    // Round robin over all eight with every line requesting: 0..7 then 0,
    // with a RELEASE cycle and an IDLE cycle between consecutive grants.
    do_reset();
    enable = 1'b1; req = 8'hFF; done = 1'b0;
    for (int n = 0; n < 9; n++) begin
      exp_idx = 3'(n);
      waited  = 0;
      step();
      while (!grant_valid && waited < 6) begin
        waited++;
        step();
      end
      check($sformatf("rr%0d.seen", n), 32'(grant_valid), 32'd1);
      check($sformatf("rr%0d.idx", n), 32'(grant_idx), 32'(exp_idx));
      check($sformatf("rr%0d.grant", n), 32'(grant), 32'(8'd1 << exp_idx));
      if (n > 0) check($sformatf("rr%0d.gap", n), 32'(waited + 1), 32'd2);
      done = 1'b1;
      step();
      done = 1'b0;
      check($sformatf("rr%0d.rel", n), 32'(grant), 32'h00);
    end

    // Long hold on a single requester.
    do_reset();
    enable = 1'b1; req = 8'h04; done = 1'b0;
    step();
    check_all("hold.first", 1'b1, 3'd2, 8'h04, 1'b0);
`ifdef DECODER_ARB_TIMEOUT_EN
    hold = 1;
    while (grant_valid && hold < 10) begin
      step();
      if (grant_valid) hold++;
    end
    check("tmo.len", 32'(hold), 32'd4);
    check_all("tmo.pulse", 1'b0, 3'd2, 8'h00, 1'b1);
    step();
    check_all("tmo.after", 1'b0, 3'd2, 8'h00, 1'b0);
    // A done on the terminal cycle is a normal release, not a timeout.
    step();
    check_all("tmo2.first", 1'b1, 3'd2, 8'h04, 1'b0);
    step();
    step();
    step();
    check_all("tmo2.last", 1'b1, 3'd2, 8'h04, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    check_all("tmo2.rel", 1'b0, 3'd2, 8'h00, 1'b0);
`else
    persist_ok = 1'b1;
    for (int c = 0; c < 120; c++) begin
      step();
      if (!grant_valid || grant !== 8'h04 || timeout !== 1'b0) persist_ok = 1'b0;
    end
    check("persist", 32'(persist_ok), 32'd1);
`endif

    // Reset in the middle of a grant: no RELEASE, ptr back to 7.
    do_reset();
    enable = 1'b1; req = 8'hFF; done = 1'b0;
    step();
    check_all("rstg.g0", 1'b1, 3'd0, 8'h01, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    check_all("rstg.g1", 1'b1, 3'd1, 8'h02, 1'b0);
    rst = 1'b1;
    step();
    check_all("rstg.rst", 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;
    step();
    check_all("rstg.after", 1'b1, 3'd0, 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
